// File: rtl/mmio_host_tx_fifo_if.sv
// CPU register-window and host pipe-out signals of the MMIO transmit FIFO.
// The master modport is the CPU/host side; the slave modport is the FIFO.
interface mmio_host_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic                  cpu_en;
  logic                  cpu_wr_en;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_w_data;
  logic                  cpu_sel;
  logic [31:0]           cpu_r_data;
  logic                  pipe_read;
  logic [31:0]           pipe_data;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow;
  logic                  underrun;

  modport master (
    output cpu_en, cpu_wr_en, cpu_addr, cpu_w_data, pipe_read,
    input  cpu_sel, cpu_r_data, pipe_data, fifo_count, fifo_full, fifo_empty,
           overflow, underrun
  );

  modport slave (
    input  cpu_en, cpu_wr_en, cpu_addr, cpu_w_data, pipe_read,
    output cpu_sel, cpu_r_data, pipe_data, fifo_count, fifo_full, fifo_empty,
           overflow, underrun
  );
endinterface

// File: rtl/mmio_host_tx_fifo.sv
// CPU-to-host transmit FIFO: CPU stores push words through a 4-register window,
// the host drains them first-word-fall-through via the pipe-out read strobe.
module mmio_host_tx_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [31:0] PAD_WORD   = 32'hDEAD_BEEF
) (
  input logic                clk,
  input logic                rst,
  mmio_host_tx_fifo_if.slave bus
);
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [31:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  und_q, und_d;
  logic                  sel_q, sel_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        hit, eff, empty, full;
  logic [1:0]  offset;
  logic        push_req, push_ok, pop_ok, flush;
  logic        ovf_set, und_set, ovf_clr, und_clr;
  logic [31:0] status;

  assign hit    = bus.cpu_addr[31:4] == BASE_ADDR[31:4];
  assign eff    = bus.cpu_en && hit;
  assign offset = bus.cpu_addr[3:2];
  assign empty  = count_q == '0;
  assign full   = count_q == CntW'(Depth);
  assign status = {und_q, ovf_q, full, empty, 18'b0, 10'(count_q)};

  always_comb begin
    push_req = eff && bus.cpu_wr_en && (offset == 2'd0);
    flush    = eff && bus.cpu_wr_en && (offset == 2'd2) && bus.cpu_w_data[0];
    ovf_clr  = eff && bus.cpu_wr_en && (offset == 2'd2) && bus.cpu_w_data[1];
    und_clr  = eff && bus.cpu_wr_en && (offset == 2'd2) && bus.cpu_w_data[2];
    // A flush swallows any concurrent pop without flagging it.
    pop_ok   = bus.pipe_read && !empty && !flush;
    und_set  = bus.pipe_read && empty && !flush;
    push_ok  = push_req && (!full || pop_ok);
    ovf_set  = push_req && full && !pop_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    // Set wins over a same-cycle clear.
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    und_d = und_set ? 1'b1 : (und_clr ? 1'b0 : und_q);

    sel_d   = bus.cpu_en ? hit : sel_q;
    rdata_d = rdata_q;
    if (eff) rdata_d = (offset == 2'd1) ? status : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      sel_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= bus.cpu_w_data;
  end

  assign bus.pipe_data  = empty ? PAD_WORD : mem_q[rd_ptr_q];
  assign bus.fifo_count = count_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = ovf_q;
  assign bus.underrun   = und_q;
  assign bus.cpu_sel    = sel_q;
  assign bus.cpu_r_data = rdata_q;
endmodule
